// File: rtl/palette_mux.sv
// palette_mux: registered, runtime-programmable colour palette with
// per-entry blink and blanking-aware output on the pixel clock.
// Two-stage pipeline: stage 1 looks up the palette, stage 2 applies
// blanking and the blink phase.
module palette_mux #(
    parameter int unsigned          COLOR_W     = 24,
    parameter int unsigned          N_ENTRIES   = 4,
    parameter int unsigned          BLINK_DIV   = 30,
    parameter logic [COLOR_W-1:0]   BLINK_COLOR = '0,
    localparam int unsigned         SEL_W       = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [SEL_W-1:0]   sel,
    input  logic               de,
    input  logic               frame_tick,
    input  logic               wr_en,
    input  logic [SEL_W-1:0]   wr_addr,
    input  logic [COLOR_W-1:0] wr_data,
    input  logic               wr_blink,
    output logic [COLOR_W-1:0] display,
    output logic               display_de
);

    localparam int unsigned        CNT_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(BLINK_DIV - 1);
    localparam logic [31:0]        N_LIM    = 32'(N_ENTRIES);
    localparam logic [COLOR_W-1:0] RST_BG   = COLOR_W'(24'hE10000);
    localparam logic [COLOR_W-1:0] RST_LINE = COLOR_W'(24'hFFFFFF);

    logic [COLOR_W-1:0]   pal [N_ENTRIES];
    logic [N_ENTRIES-1:0] blink;

    logic                 sel_ok;
    logic                 wr_ok;

    logic                 de_s1;
    logic [COLOR_W-1:0]   color_s1;
    logic                 blink_s1;

    logic [CNT_W-1:0]     frame_cnt;
    logic                 phase;

    // Indices beyond the populated entries read as black and ignore writes.
    always_comb begin
        sel_ok = (32'(sel) < N_LIM);
        wr_ok  = (32'(wr_addr) < N_LIM);
    end

    // Palette storage; writes land at the edge, so a same-edge read sees the old entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_ENTRIES; i++) begin
                pal[i] <= '0;
            end
            pal[0] <= RST_BG;
            pal[1] <= RST_LINE;
            blink  <= '0;
        end else if (wr_en && wr_ok) begin
            pal[wr_addr]   <= wr_data;
            blink[wr_addr] <= wr_blink;
        end
    end

    // Stage 1: palette lookup and display-enable capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_s1    <= 1'b0;
            color_s1 <= '0;
            blink_s1 <= 1'b0;
        end else begin
            de_s1 <= de;
            if (sel_ok) begin
                color_s1 <= pal[sel];
                blink_s1 <= blink[sel];
            end else begin
                color_s1 <= '0;
                blink_s1 <= 1'b0;
            end
        end
    end

    // Stage 2: blanking and blink substitution into the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            display    <= '0;
            display_de <= 1'b0;
        end else begin
            display_de <= de_s1;
            if (!de_s1) begin
                display <= '0;
            end else if (blink_s1 && phase) begin
                display <= BLINK_COLOR;
            end else begin
                display <= color_s1;
            end
        end
    end

    // Blink timer: phase toggles every BLINK_DIV frame ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            phase     <= 1'b0;
        end else if (frame_tick) begin
            if (frame_cnt == CNT_LAST) begin
                frame_cnt <= '0;
                phase     <= ~phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_palette_mux.sv
// Self-checking bench for palette_mux. Two instances share the stimulus:
// a 4-entry palette with BLINK_DIV=2 and a distinct blink colour, and a
// 3-entry palette with BLINK_DIV=3 to exercise out-of-range indices.
module tb_palette_mux;

    localparam logic [23:0] BC0 = 24'h0A0B0C;

    logic        clk;
    logic        rst_n;
    logic [1:0]  sel;
    logic        de;
    logic        frame_tick;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [23:0] wr_data;
    logic        wr_blink;
    logic [23:0] display0, display1;
    logic        display_de0, display_de1;

    int unsigned n_cmp = 0;
    int unsigned n_mis = 0;

    palette_mux #(
        .COLOR_W     (24),
        .N_ENTRIES   (4),
        .BLINK_DIV   (2),
        .BLINK_COLOR (BC0)
    ) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .sel        (sel),
        .de         (de),
        .frame_tick (frame_tick),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_blink   (wr_blink),
        .display    (display0),
        .display_de (display_de0)
    );

    palette_mux #(
        .COLOR_W     (24),
        .N_ENTRIES   (3),
        .BLINK_DIV   (3),
        .BLINK_COLOR (24'h000000)
    ) dut3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .sel        (sel),
        .de         (de),
        .frame_tick (frame_tick),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_blink   (wr_blink),
        .display    (display1),
        .display_de (display_de1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        de;
        logic        blk;
        logic [23:0] col;
    } pix_t;

    pix_t        q0[$];
    pix_t        q1[$];
    logic [23:0] mpal [2][4];
    logic        mblk [2][4];
    int unsigned ticks;

    function automatic int unsigned ne(int i);
        return (i == 0) ? 4 : 3;
    endfunction

    function automatic int unsigned dv(int i);
        return (i == 0) ? 2 : 3;
    endfunction

    function automatic logic [23:0] bcol(int i);
        return (i == 0) ? BC0 : 24'h000000;
    endfunction

    task automatic model_reset();
        q0.delete();
        q1.delete();
        ticks = 0;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 4; j++) begin
                mpal[i][j] = (j == 0) ? 24'hE10000 : (j == 1) ? 24'hFFFFFF : 24'h000000;
                mblk[i][j] = 1'b0;
            end
        end
    endtask

    function automatic pix_t lookup(int i, logic d, logic [1:0] s);
        pix_t p;
        p.de = d;
        if (int'(s) < int'(ne(i))) begin
            p.col = mpal[i][s];
            p.blk = mblk[i][s];
        end else begin
            p.col = 24'h000000;
            p.blk = 1'b0;
        end
        return p;
    endfunction

    // Phase is "off" during odd-numbered blink half-periods since reset.
    function automatic logic [23:0] render(int i, pix_t p, int unsigned t);
        if (!p.de)                           return 24'h000000;
        if (p.blk && ((t / dv(i)) % 2 == 1)) return bcol(i);
        return p.col;
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock edge, update the model with the sampled inputs, check outputs.
    task automatic step();
        pix_t        p;
        logic [23:0] e_d0, e_d1;
        logic        e_de0, e_de1;
        @(posedge clk);
        e_d0 = '0; e_d1 = '0; e_de0 = 1'b0; e_de1 = 1'b0;
        if (!rst_n) begin
            model_reset();
        end else begin
            if (q0.size() > 0) begin
                p = q0.pop_front();
                e_d0 = render(0, p, ticks);
                e_de0 = p.de;
            end
            if (q1.size() > 0) begin
                p = q1.pop_front();
                e_d1 = render(1, p, ticks);
                e_de1 = p.de;
            end
            q0.push_back(lookup(0, de, sel));
            q1.push_back(lookup(1, de, sel));
            if (frame_tick) ticks++;
            if (wr_en) begin
                for (int i = 0; i < 2; i++) begin
                    if (int'(wr_addr) < int'(ne(i))) begin
                        mpal[i][wr_addr] = wr_data;
                        mblk[i][wr_addr] = wr_blink;
                    end
                end
            end
        end
        #1;
        chk("display4", 32'(display0), 32'(e_d0));
        chk("de4", 32'(display_de0), 32'(e_de0));
        chk("display3", 32'(display1), 32'(e_d1));
        chk("de3", 32'(display_de1), 32'(e_de1));
    endtask

    task automatic drive(logic [1:0] s, logic d, logic ft, logic we,
                         logic [1:0] wa, logic [23:0] wd, logic wb);
        sel = s; de = d; frame_tick = ft;
        wr_en = we; wr_addr = wa; wr_data = wd; wr_blink = wb;
        step();
    endtask

    task automatic drive_random(int unsigned n);
        for (int k = 0; k < int'(n); k++) begin
            drive(2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 7) == 0),
                  2'($urandom_range(0, 3)), 24'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        sel = '0; de = 1'b0; frame_tick = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_blink = 1'b0;
        model_reset();
        #1;
        chk("rst_display4", 32'(display0), 32'h0);
        chk("rst_de4", 32'(display_de0), 32'h0);
        step();
        step();
        #2 rst_n = 1'b1;

        // Reset defaults through the pipeline.
        repeat (3) drive(2'd0, 1'b1, 1'b0, 1'b0, 2'd0, 24'h0, 1'b0);
        repeat (3) drive(2'd1, 1'b1, 1'b0, 1'b0, 2'd0, 24'h0, 1'b0);
        // Blanking and de toggling.
        repeat (2) drive(2'd1, 1'b0, 1'b0, 1'b0, 2'd0, 24'h0, 1'b0);
        for (int k = 0; k < 6; k++) drive(2'd1, 1'(k % 2), 1'b0, 1'b0, 2'd0, 24'h0, 1'b0);
        // Read/write collision on entry 2.
        drive(2'd2, 1'b1, 1'b0, 1'b1, 2'd2, 24'h00FF00, 1'b0);
        repeat (3) drive(2'd2, 1'b1, 1'b0, 1'b0, 2'd0, 24'h0, 1'b0);
        // Blinking entry 3 interleaved with non-blinking entry 1.
        drive(2'd0, 1'b1, 1'b0, 1'b1, 2'd3, 24'h123456, 1'b1);
        for (int k = 0; k < 60; k++)
            drive((k % 2 == 0) ? 2'd3 : 2'd1, 1'b1, 1'(k % 10 == 9), 1'b0, 2'd0, 24'h0, 1'b0);
        // Out-of-range selector on the 3-entry instance.
        repeat (3) drive(2'd3, 1'b1, 1'b0, 1'b0, 2'd0, 24'h0, 1'b0);

        drive_random(300);

        // Asynchronous reset between edges clears outputs without waiting for a clock.
        #2 rst_n = 1'b0;
        #1;
        chk("async_display4", 32'(display0), 32'h0);
        chk("async_de4", 32'(display_de0), 32'h0);
        chk("async_display3", 32'(display1), 32'h0);
        chk("async_de3", 32'(display_de1), 32'h0);
        model_reset();
        step();
        #2 rst_n = 1'b1;
        for (int k = 0; k < 8; k++) drive(2'(k % 4), 1'b1, 1'b0, 1'b0, 2'd0, 24'h0, 1'b0);

        drive_random(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/palette_mux.md
Name: palette_mux

Overview:
- Registered, programmable color palette for the VGA driver.
- Maps a per-pixel element selector (background, grid lines, tokens, cursor, ...) to a COLOR_W-bit RGB value from a runtime-writable palette.
- Adds per-entry blink, blanking-aware output and a fixed 2-cycle pipeline.
- Sits between the pixel-classification logic and the VGA output register, on the pixel clock.

Parameters:
- COLOR_W, 24, RGB width: [23:16] blue, [15:8] green, [7:0] red.
- N_ENTRIES, 4, number of palette entries (>=2). Local SEL_W = max(1, clog2(N_ENTRIES)).
- BLINK_DIV, 30, number of frame_tick pulses per blink half-period (>=1).
- BLINK_COLOR, 24'h000000, color shown by a blinking entry during the off phase.

Ports:
- clk  in  1  pixel clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- sel  in  SEL_W  palette index for the current pixel
- de  in  1  display enable; 0 = blanking
- frame_tick  in  1  single-cycle pulse once per frame
- wr_en  in  1  palette write strobe
- wr_addr  in  SEL_W  palette entry to write
- wr_data  in  COLOR_W  color to write
- wr_blink  in  1  blink-enable bit written with the entry
- display  out  COLOR_W  pixel color, 2-cycle latency
- display_de  out  1  de delayed 2 cycles, aligned with display

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Palette: entry0 = 24'hE10000 (background blue), entry1 = 24'hFFFFFF (lines white), all others 0.
  - All blink bits = 0.
  - Pipeline registers, display and display_de = 0.
  - Frame counter = 0, blink phase = 0 (on).
- Stage 1 (cycle N+1):
  - Registers de.
  - Registers palette[sel] and blink[sel] when sel < N_ENTRIES.
  - When sel >= N_ENTRIES, registers color 0 with blink 0.
- Stage 2 (cycle N+2):
  - de_s1=0: display = 0.
  - de_s1=1, blink_s1=1, phase=1: display = BLINK_COLOR.
  - Otherwise: display = color_s1.
  - display_de = de_s1.
- Latency: input sampled at edge N appears on display after edge N+2. Throughput: one pixel per clock, no stalls.
- Palette write:
  - Entry wr_addr ← {wr_blink, wr_data} at the edge where wr_en=1.
  - wr_addr >= N_ENTRIES: write ignored.
  - Read/write collision: a stage-1 read of the same entry at the same edge captures the OLD value. The new value applies to pixels whose sel is sampled at the next edge onward. No bypass.
- Blink timer:
  - On frame_tick=1: if frame counter == BLINK_DIV-1, counter ← 0 and phase toggles; else counter increments.
  - frame_tick=0 holds state.
  - Phase is read by stage 2, so a toggle at edge K affects display from edge K+1.
- Simultaneous wr_en and frame_tick: independent, both take effect.
- Reset mid-frame clears everything immediately. First valid output appears 2 edges after rst_n deasserts with de=1.
- No combinational path from any input to any output.

Test Plan:
- Reset, then de=1, sel=0 for 3 cycles → display = 24'hE10000 from 2nd edge, display_de=1. sel=1 → 24'hFFFFFF exactly 2 edges later.
- de=0 with sel=1 → display = 0, display_de = 0, two edges later. Toggle de every cycle → display_de reproduces the pattern delayed by 2.
- Write wr_addr=2, wr_data=24'h00FF00 at the same edge sel=2 is sampled → that pixel shows 0 (old value); next pixel with sel=2 shows 24'h00FF00.
- Write entry 3 = 24'h123456 with wr_blink=1, hold sel=3, de=1, BLINK_DIV=2, pulse frame_tick every 10 cycles:
  - Output is 24'h123456 until the 2nd tick.
  - Then BLINK_COLOR until the 4th tick, then alternates.
  - Entry 1 held in parallel never blinks.
- sel=3 with N_ENTRIES=3 (override) → display = 0. Write to wr_addr=3 leaves entries 0-2 unchanged.
- Assert rst_n=0 mid-stream, asynchronously between edges:
  - display, display_de and phase clear immediately.
  - Previously written entries revert to reset defaults.
